// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared types for the load/store unit and its byte-lane helper.
//   mem_size_e      access size encoding (B/H/W/D), matches req_size
//   lsu_state_e     load/store unit FSM states
//   LANE_BYTES      number of byte lanes in one memory word
//   misaligned_addr true when a byte offset is not a multiple of the size
// ---------------------------------------------------------------------------
package mem_pkg;

    localparam int LANE_BYTES = 8;

    typedef enum logic [1:0] {
        MEM_B = 2'd0,
        MEM_H = 2'd1,
        MEM_W = 2'd2,
        MEM_D = 2'd3
    } mem_size_e;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        WR_ISSUE,
        RESP
    } lsu_state_e;

    function automatic logic misaligned_addr(logic [2:0] offset, mem_size_e size);
        case (size)
            MEM_B:   return 1'b0;
            MEM_H:   return offset[0];
            MEM_W:   return |offset[1:0];
            default: return |offset;
        endcase
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// ---------------------------------------------------------------------------
// lsu_byte_lane
// Combinational byte-lane steering for one 64-bit little-endian word.
//   word         in  64  word read from memory
//   wdata        in  64  right-justified store data
//   offset       in  3   byte offset of the access inside the word
//   size         in  2   access size (mem_size_e)
//   is_unsigned  in  1   1 = zero-extend loads, 0 = sign-extend
//   load_data    out 64  selected lane, extended to 64 bits
//   merged_word  out 64  word with the store bytes replaced
// Offsets are assumed aligned to the size, so a lane never crosses the word.
// ---------------------------------------------------------------------------
module lsu_byte_lane
    import mem_pkg::*;
(
    input  logic [LANE_BYTES*8-1:0] word,
    input  logic [LANE_BYTES*8-1:0] wdata,
    input  logic [2:0]              offset,
    input  mem_size_e               size,
    input  logic                    is_unsigned,
    output logic [LANE_BYTES*8-1:0] load_data,
    output logic [LANE_BYTES*8-1:0] merged_word
);

    logic [5:0]              shamt;
    logic [LANE_BYTES*8-1:0] lane_mask;
    logic [LANE_BYTES*8-1:0] shifted;
    logic                    sign_bit;

    assign shamt   = {offset, 3'b000};
    assign shifted = word >> shamt;

    always_comb begin
        case (size)
            MEM_B:   lane_mask = 64'h0000_0000_0000_00FF;
            MEM_H:   lane_mask = 64'h0000_0000_0000_FFFF;
            MEM_W:   lane_mask = 64'h0000_0000_FFFF_FFFF;
            default: lane_mask = '1;
        endcase
    end

    // The sign bit is the top bit of the lane; D accesses have nothing to extend.
    always_comb begin
        case (size)
            MEM_B:   sign_bit = shifted[7];
            MEM_H:   sign_bit = shifted[15];
            MEM_W:   sign_bit = shifted[31];
            default: sign_bit = 1'b0;
        endcase
        load_data = shifted & lane_mask;
        if (!is_unsigned && sign_bit) begin
            load_data = load_data | ~lane_mask;
        end
    end

    assign merged_word = (word & ~(lane_mask << shamt)) | ((wdata & lane_mask) << shamt);

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// Memory-stage load/store front end driving a word-granular memory port.
// One request at a time; sub-word stores are done as read-modify-write.
//   clk, reset_n        clock, synchronous active-low reset
//   req_*               request handshake and fields (latched on accept)
//   resp_*              response handshake, extended load data, misalign flag
//   mem_addr            word-aligned address, stable for the whole transaction
//   mem_read_en/_write_en, mem_write_data, mem_read_data, mem_ready
//                       word port; read data is valid the cycle after an
//                       accepted read strobe
// ---------------------------------------------------------------------------
module load_store_unit
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_misaligned,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic                  mem_read_en,
    output logic                  mem_write_en,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    input  logic                  mem_ready
);

    lsu_state_e state, next_state;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [2:0]            offset_q;
    mem_size_e             size_q;
    logic                  write_q;
    logic                  unsigned_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] wr_word_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  misaligned_q;

    logic                  req_misaligned;
    logic [DATA_WIDTH-1:0] load_data;
    logic [DATA_WIDTH-1:0] merged_word;

    assign req_misaligned = misaligned_addr(req_addr[2:0], mem_size_e'(req_size));

    lsu_byte_lane u_byte_lane (
        .word        (mem_read_data),
        .wdata       (wdata_q),
        .offset      (offset_q),
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Aligned D stores skip the read; every other aligned access reads first.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_misaligned) begin
                        next_state = RESP;
                    end else if (req_write && mem_size_e'(req_size) == MEM_D) begin
                        next_state = WR_ISSUE;
                    end else begin
                        next_state = RD_ISSUE;
                    end
                end
            end
            RD_ISSUE: if (mem_ready)  next_state = RD_WAIT;
            RD_WAIT:  next_state = write_q ? WR_ISSUE : RESP;
            WR_ISSUE: if (mem_ready)  next_state = RESP;
            RESP:     if (resp_ready) next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    always_comb begin
        req_ready      = (state == IDLE);
        mem_read_en    = (state == RD_ISSUE);
        mem_write_en   = (state == WR_ISSUE);
        resp_valid     = (state == RESP);
        mem_write_data = (state == WR_ISSUE) ? wr_word_q : '0;
    end

    assign mem_addr        = addr_q;
    assign resp_rdata      = rdata_q;
    assign resp_misaligned = misaligned_q;

    // wr_word_q is preloaded with the store data so a D store can write it
    // directly; sub-word stores overwrite it with the merged word in RD_WAIT.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            addr_q       <= '0;
            offset_q     <= '0;
            size_q       <= MEM_B;
            write_q      <= 1'b0;
            unsigned_q   <= 1'b0;
            wdata_q      <= '0;
            wr_word_q    <= '0;
            rdata_q      <= '0;
            misaligned_q <= 1'b0;
        end else if (state == IDLE && req_valid) begin
            addr_q       <= {req_addr[ADDR_WIDTH-1:3], 3'b000};
            offset_q     <= req_addr[2:0];
            size_q       <= mem_size_e'(req_size);
            write_q      <= req_write;
            unsigned_q   <= req_unsigned;
            wdata_q      <= req_wdata;
            wr_word_q    <= req_wdata;
            rdata_q      <= '0;
            misaligned_q <= req_misaligned;
        end else if (state == RD_WAIT) begin
            if (write_q) begin
                wr_word_q <= merged_word;
            end else begin
                rdata_q <= load_data;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [63:0] resp_rdata;
    logic        resp_misaligned;
    logic [63:0] mem_addr;
    logic [63:0] mem_write_data;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [63:0] mem_read_data = '0;
    logic        mem_ready = 1'b1;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_size        (req_size),
        .req_unsigned    (req_unsigned),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_rdata      (resp_rdata),
        .resp_misaligned (resp_misaligned),
        .mem_addr        (mem_addr),
        .mem_write_data  (mem_write_data),
        .mem_read_en     (mem_read_en),
        .mem_write_en    (mem_write_en),
        .mem_read_data   (mem_read_data),
        .mem_ready       (mem_ready)
    );

    // Stub word memory: 32 words, read data registered one cycle after an accepted strobe.
    logic [63:0] stub_mem [0:31] = '{default: 64'd0};
    int read_count = 0;
    int write_count = 0;
    int overlap_count = 0;

    always @(posedge clk) begin
        if (mem_read_en && mem_ready) begin
            mem_read_data <= stub_mem[mem_addr[7:3]];
            read_count    <= read_count + 1;
        end
        if (mem_write_en && mem_ready) begin
            stub_mem[mem_addr[7:3]] <= mem_write_data;
            write_count             <= write_count + 1;
        end
        if (mem_read_en && mem_write_en) begin
            overlap_count <= overlap_count + 1;
        end
    end

    // Reference model: a flat byte-addressed memory, little-endian.
    logic [7:0] ref_mem [0:255];

    function automatic logic model_misaligned(logic [7:0] addr, logic [1:0] size);
        int n;
        n = 1 << size;
        return (int'(addr) % n) != 0;
    endfunction

    function automatic logic [63:0] model_load(logic [7:0] addr, logic [1:0] size, logic uns);
        int n;
        logic [63:0] v;
        n = 1 << size;
        v = '0;
        for (int i = 0; i < n; i++) begin
            v = v | (64'(ref_mem[int'(addr) + i]) << (8 * i));
        end
        if (!uns && n < 8 && v[8 * n - 1]) begin
            v = v | ~((64'd1 << (8 * n)) - 64'd1);
        end
        return v;
    endfunction

    task automatic model_store(input logic [7:0] addr, input logic [1:0] size, input logic [63:0] wdata);
        int n;
        n = 1 << size;
        for (int i = 0; i < n; i++) begin
            ref_mem[int'(addr) + i] = 8'(wdata >> (8 * i));
        end
    endtask

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Issues one request, waits (bounded) for the response and handshakes it.
    task automatic apply_stimulus(input logic wr, input logic [1:0] size, input logic uns,
                                  input logic [63:0] addr, input logic [63:0] wdata,
                                  output logic [63:0] rdata, output logic mis, output int lat,
                                  output int reads, output int writes);
        int r0;
        int w0;
        bit found;
        r0 = read_count;
        w0 = write_count;
        @(negedge clk);
        check_output("req_ready_idle", 64'(req_ready), 64'd1);
        req_valid    = 1'b1;
        req_write    = wr;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_wdata = 64'hDEAD_BEEF_DEAD_BEEF;
        found = 1'b0;
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = c;
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            check_output("resp_timeout", 64'd0, 64'd1);
        end
        rdata = resp_rdata;
        mis   = resp_misaligned;
        @(posedge clk);
        #1;
        reads  = read_count - r0;
        writes = write_count - w0;
    endtask

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_rdata;
        logic        exp_mis;
        int          exp_lat;
        int          exp_reads;
        int          exp_writes;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [63:0] rdata;
        logic [63:0] held;
        logic        mis;
        int          lat;
        int          reads;
        int          writes;
        int          r0;
        int          w0;
        bit          found;

        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("rst_req_ready", 64'(req_ready), 64'd1);
        check_output("rst_resp_valid", 64'(resp_valid), 64'd0);
        check_output("rst_mem_read_en", 64'(mem_read_en), 64'd0);
        check_output("rst_mem_write_en", 64'(mem_write_en), 64'd0);
        check_output("rst_mem_addr", mem_addr, 64'd0);
        check_output("rst_mem_write_data", mem_write_data, 64'd0);
        check_output("rst_resp_rdata", resp_rdata, 64'd0);
        check_output("rst_resp_misaligned", 64'(resp_misaligned), 64'd0);
        reset_n = 1'b1;

        // Directed vectors: wr size uns addr wdata | rdata mis lat reads writes
        vecs.push_back('{1'b1, 2'd3, 1'b0, 64'h40, 64'h1122334455667788, 64'h0, 1'b0, 2, 0, 1});
        vecs.push_back('{1'b0, 2'd3, 1'b0, 64'h40, 64'h0, 64'h1122334455667788, 1'b0, 3, 1, 0});
        vecs.push_back('{1'b1, 2'd0, 1'b0, 64'h43, 64'hFFFF_FFFF_FFFF_FFAB, 64'h0, 1'b0, 4, 1, 1});
        vecs.push_back('{1'b0, 2'd3, 1'b0, 64'h40, 64'h0, 64'h11223344AB667788, 1'b0, 3, 1, 0});
        vecs.push_back('{1'b0, 2'd0, 1'b0, 64'h43, 64'h0, 64'hFFFFFFFFFFFFFFAB, 1'b0, 3, 1, 0});
        vecs.push_back('{1'b0, 2'd0, 1'b1, 64'h43, 64'h0, 64'h00000000000000AB, 1'b0, 3, 1, 0});
        vecs.push_back('{1'b0, 2'd1, 1'b0, 64'h42, 64'h0, 64'hFFFFFFFFFFFFAB66, 1'b0, 3, 1, 0});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 64'h42, 64'h0, 64'h0, 1'b1, 1, 0, 0});
        vecs.push_back('{1'b1, 2'd1, 1'b0, 64'h46, 64'h5555_1234, 64'h0, 1'b0, 4, 1, 1});
        vecs.push_back('{1'b0, 2'd2, 1'b1, 64'h44, 64'h0, 64'h0000000012343344, 1'b0, 3, 1, 0});
        vecs.push_back('{1'b1, 2'd2, 1'b0, 64'h48, 64'h89ABCDEF80000001, 64'h0, 1'b0, 4, 1, 1});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 64'h48, 64'h0, 64'hFFFFFFFF80000001, 1'b0, 3, 1, 0});
        vecs.push_back('{1'b0, 2'd3, 1'b0, 64'h48, 64'h0, 64'h0000000080000001, 1'b0, 3, 1, 0});
        vecs.push_back('{1'b1, 2'd3, 1'b0, 64'h41, 64'h1, 64'h0, 1'b1, 1, 0, 0});
        vecs.push_back('{1'b0, 2'd1, 1'b1, 64'h47, 64'h0, 64'h0, 1'b1, 1, 0, 0});

        foreach (vecs[k]) begin
            apply_stimulus(vecs[k].wr, vecs[k].size, vecs[k].uns, vecs[k].addr, vecs[k].wdata,
                           rdata, mis, lat, reads, writes);
            check_output($sformatf("vec%0d_rdata", k), rdata, vecs[k].exp_rdata);
            check_output($sformatf("vec%0d_misaligned", k), 64'(mis), 64'(vecs[k].exp_mis));
            check_output($sformatf("vec%0d_latency", k), 64'(lat), 64'(vecs[k].exp_lat));
            check_output($sformatf("vec%0d_reads", k), 64'(reads), 64'(vecs[k].exp_reads));
            check_output($sformatf("vec%0d_writes", k), 64'(writes), 64'(vecs[k].exp_writes));
            if (vecs[k].wr && !vecs[k].exp_mis) begin
                model_store(vecs[k].addr[7:0], vecs[k].size, vecs[k].wdata);
            end
        end

        // Stalls: mem_ready low 3 cycles in RD_ISSUE, resp_ready low 2 cycles in RESP.
        r0 = read_count;
        @(negedge clk);
        mem_ready    = 1'b0;
        resp_ready   = 1'b0;
        req_valid    = 1'b1;
        req_write    = 1'b0;
        req_size     = 2'd3;
        req_unsigned = 1'b0;
        req_addr     = 64'h40;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_output("stall_read_en_held", 64'(mem_read_en), 64'd1);
            check_output("stall_req_ready", 64'(req_ready), 64'd0);
            check_output("stall_mem_addr", mem_addr, 64'h40);
        end
        mem_ready = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (resp_valid) begin
                found = 1'b1;
                break;
            end
        end
        check_output("stall_resp_seen", 64'(found), 64'd1);
        held = resp_rdata;
        check_output("stall_rdata", held, model_load(8'h40, 2'd3, 1'b0));
        @(negedge clk);
        check_output("stall_resp_valid_held", 64'(resp_valid), 64'd1);
        check_output("stall_rdata_stable", resp_rdata, held);
        check_output("stall_req_ready_resp", 64'(req_ready), 64'd0);
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_output("stall_resp_released", 64'(resp_valid), 64'd0);
        check_output("stall_req_ready_after", 64'(req_ready), 64'd1);
        check_output("stall_single_read", 64'(read_count - r0), 64'd1);

        // Reset during RD_WAIT of a B store aborts it.
        w0 = write_count;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size  = 2'd0;
        req_addr  = 64'h53;
        req_wdata = 64'h5A;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_output("abort_write_en", 64'(mem_write_en), 64'd0);
        check_output("abort_read_en", 64'(mem_read_en), 64'd0);
        check_output("abort_resp_valid", 64'(resp_valid), 64'd0);
        check_output("abort_req_ready", 64'(req_ready), 64'd1);
        check_output("abort_mem_addr", mem_addr, 64'd0);
        check_output("abort_write_data", mem_write_data, 64'd0);
        reset_n = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (resp_valid) found = 1'b1;
        end
        check_output("abort_no_response", 64'(found), 64'd0);
        check_output("abort_no_write", 64'(write_count - w0), 64'd0);
        apply_stimulus(1'b0, 2'd3, 1'b0, 64'h50, 64'h0, rdata, mis, lat, reads, writes);
        check_output("abort_word_unchanged", rdata, model_load(8'h50, 2'd3, 1'b0));

        // Random transactions against the byte-level model.
        for (int t = 0; t < 60; t++) begin
            logic        wr;
            logic [1:0]  size;
            logic        uns;
            logic [7:0]  addr;
            logic [63:0] wdata;
            logic        exp_mis;
            logic [63:0] exp_rdata;
            int          exp_lat;
            wr    = 1'($urandom_range(0, 1));
            size  = 2'($urandom_range(0, 3));
            uns   = 1'($urandom_range(0, 1));
            addr  = 8'($urandom_range(0, 255));
            wdata = {32'($urandom), 32'($urandom)};
            if ($urandom_range(0, 3) != 0) begin
                addr = addr & ~8'((1 << size) - 1);
            end
            exp_mis   = model_misaligned(addr, size);
            exp_rdata = (exp_mis || wr) ? 64'd0 : model_load(addr, size, uns);
            if (exp_mis)            exp_lat = 1;
            else if (!wr)           exp_lat = 3;
            else if (size == 2'd3)  exp_lat = 2;
            else                    exp_lat = 4;
            apply_stimulus(wr, size, uns, 64'(addr), wdata, rdata, mis, lat, reads, writes);
            check_output($sformatf("rnd%0d_rdata", t), rdata, exp_rdata);
            check_output($sformatf("rnd%0d_misaligned", t), 64'(mis), 64'(exp_mis));
            check_output($sformatf("rnd%0d_latency", t), 64'(lat), 64'(exp_lat));
            check_output($sformatf("rnd%0d_reads", t), 64'(reads),
                         64'((!exp_mis && !(wr && size == 2'd3)) ? 1 : 0));
            check_output($sformatf("rnd%0d_writes", t), 64'(writes), 64'((!exp_mis && wr) ? 1 : 0));
            if (wr && !exp_mis) model_store(addr, size, wdata);
        end

        check_output("strobe_overlap", 64'(overlap_count), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
